dmem_responder: RTL and testbench

Data-memory responder for the pipelined core's memory stage, serving the other end of the core's M-stage data interface. It accepts the core's address, write data and write enable each cycle and returns read data in the same cycle, so the core's writeback register captures it at the next edge. It holds a word RAM behind a one-entry posted write buffer, plus a small MMIO block with a free-running cycle counter, a down-counting timer and a status register.

---
 rtl/dmem_pkg.sv | 17 +
 rtl/dmem_timer.sv | 64 ++++++
 rtl/dmem_responder.sv | 116 +++++++++++
 tb/tb_dmem_responder.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared constants and types for the data-memory responder
package dmem_pkg;

    localparam logic [31:0] MMIO_CYCLE_OFF  = 32'h0;
    localparam logic [31:0] MMIO_TIMER_OFF  = 32'h4;
    localparam logic [31:0] MMIO_STATUS_OFF = 32'h8;

    localparam int unsigned STATUS_EXPIRED_BIT = 0;
    localparam int unsigned STATUS_FAULT_BIT   = 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2
    } timer_state_e;

endpackage

// File: rtl/dmem_timer.sv
// rtl/dmem_timer.sv - down-counting MMIO timer with load strobe and expire pulse
module dmem_timer
    import dmem_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic [31:0] load_val_i,
    output logic [31:0] count_o,
    output logic        expire_o
);

    timer_state_e state_q, state_d;
    logic [31:0]  count_q, count_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // A load always takes priority over the countdown, even on the expiring cycle.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        unique case (state_q)
            IDLE, EXPIRED: begin
                if (load_i && (load_val_i != 32'd0)) begin
                    state_d = RUN;
                    count_d = load_val_i;
                end
            end
            RUN: begin
                if (load_i) begin
                    if (load_val_i == 32'd0) begin
                        state_d = IDLE;
                        count_d = '0;
                    end else begin
                        count_d = load_val_i;
                    end
                end else if (count_q == 32'd1) begin
                    state_d = EXPIRED;
                    count_d = '0;
                end else begin
                    count_d = count_q - 32'd1;
                end
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase
    end

    always_comb begin
        count_o  = count_q;
        expire_o = (state_q == RUN) && !load_i && (count_q == 32'd1);
    end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - M-stage data memory: word RAM with posted write buffer plus MMIO block
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH     = 64,
    parameter logic [31:0] MMIO_BASE = 32'h0000_0800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_dm,
    input  logic [31:0] addr,
    input  logic [31:0] wd,
    output logic [31:0] rd_dm,
    output logic        timer_irq,
    output logic        fault
);

    localparam int unsigned AW        = $clog2(DEPTH);
    localparam logic [31:0] RAM_BYTES = 32'(DEPTH * 4);

    logic [31:0]   mem_q [DEPTH];

    logic          buf_valid_q, buf_valid_d;
    logic [AW-1:0] buf_idx_q,   buf_idx_d;
    logic [31:0]   buf_data_q,  buf_data_d;

    logic [31:0]   cycle_q, cycle_d;
    logic [1:0]    status_q, status_d;

    logic [AW-1:0] idx;
    logic [31:0]   mmio_off;
    logic          aligned, ram_hit, cyc_hit, tmr_hit, st_hit;
    logic          ram_we, tmr_load, st_w1c, fault_set;
    logic [31:0]   tmr_count;
    logic          tmr_expire;

    // Address decode; RAM and MMIO windows never overlap since MMIO_BASE >= DEPTH*4.
    always_comb begin
        idx      = addr[AW+1:2];
        mmio_off = addr - MMIO_BASE;
        aligned  = (addr[1:0] == 2'b00);
        ram_hit  = aligned && (addr < RAM_BYTES);
        cyc_hit  = aligned && !ram_hit && (addr >= MMIO_BASE) && (mmio_off == MMIO_CYCLE_OFF);
        tmr_hit  = aligned && !ram_hit && (addr >= MMIO_BASE) && (mmio_off == MMIO_TIMER_OFF);
        st_hit   = aligned && !ram_hit && (addr >= MMIO_BASE) && (mmio_off == MMIO_STATUS_OFF);

        ram_we    = we_dm && ram_hit;
        tmr_load  = we_dm && tmr_hit;
        st_w1c    = we_dm && st_hit;
        fault_set = we_dm && !(ram_hit || cyc_hit || tmr_hit || st_hit);
    end

    dmem_timer u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load),
        .load_val_i (wd),
        .count_o    (tmr_count),
        .expire_o   (tmr_expire)
    );

    always_comb begin
        rd_dm = '0;
        if (ram_hit) begin
            rd_dm = (buf_valid_q && (buf_idx_q == idx)) ? buf_data_q : mem_q[idx];
        end else if (cyc_hit) begin
            rd_dm = cycle_q;
        end else if (tmr_hit) begin
            rd_dm = tmr_count;
        end else if (st_hit) begin
            rd_dm = {30'd0, status_q};
        end
    end

    // Hardware set wins over a simultaneous write-1-to-clear.
    always_comb begin
        buf_valid_d = ram_we;
        buf_idx_d   = ram_we ? idx : buf_idx_q;
        buf_data_d  = ram_we ? wd  : buf_data_q;
        cycle_d     = cycle_q + 32'd1;
        status_d    = status_q;
        status_d[STATUS_EXPIRED_BIT] = tmr_expire
            || (status_q[STATUS_EXPIRED_BIT] && !(st_w1c && wd[STATUS_EXPIRED_BIT]));
        status_d[STATUS_FAULT_BIT] = fault_set
            || (status_q[STATUS_FAULT_BIT] && !(st_w1c && wd[STATUS_FAULT_BIT]));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_valid_q <= 1'b0;
            buf_idx_q   <= '0;
            buf_data_q  <= '0;
            cycle_q     <= '0;
            status_q    <= '0;
        end else begin
            buf_valid_q <= buf_valid_d;
            buf_idx_q   <= buf_idx_d;
            buf_data_q  <= buf_data_d;
            cycle_q     <= cycle_d;
            status_q    <= status_d;
        end
    end

    // The old buffered entry drains into RAM on the same edge a new write refills the buffer.
    always_ff @(posedge clk) begin
        if (buf_valid_q) begin
            mem_q[buf_idx_q] <= buf_data_q;
        end
    end

    always_comb begin
        timer_irq = status_q[STATUS_EXPIRED_BIT];
        fault     = status_q[STATUS_FAULT_BIT];
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - randomized self-checking bench for dmem_responder
module tb_dmem_responder;

    localparam int unsigned DEPTH = 64;
    localparam logic [31:0] BASE  = 32'h0000_0800;
    localparam logic [31:0] A_CYC = BASE;
    localparam logic [31:0] A_TMR = BASE + 32'h4;
    localparam logic [31:0] A_ST  = BASE + 32'h8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        we_dm = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wd = '0;
    logic [31:0] rd_dm;
    logic        timer_irq;
    logic        fault;

    dmem_responder #(.DEPTH(DEPTH), .MMIO_BASE(BASE)) dut (
        .clk       (clk),
        .rst       (rst),
        .we_dm     (we_dm),
        .addr      (addr),
        .wd        (wd),
        .rd_dm     (rd_dm),
        .timer_irq (timer_irq),
        .fault     (fault)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] m_mem   [DEPTH];
    bit          m_known [DEPTH];
    logic [31:0] m_cyc;
    logic [31:0] m_tcount;
    bit          m_trun, m_exp, m_flt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic m_reset();
        m_cyc    = '0;
        m_tcount = '0;
        m_trun   = 0;
        m_exp    = 0;
        m_flt    = 0;
    endtask

    task automatic m_read(input logic [31:0] a, output logic [31:0] v, output bit known);
        known = 1;
        v     = '0;
        if (a[1:0] != 2'b00) v = '0;
        else if (a < DEPTH * 4) begin
            known = m_known[a >> 2];
            v     = m_mem[a >> 2];
        end
        else if (a == A_CYC) v = m_cyc;
        else if (a == A_TMR) v = m_tcount;
        else if (a == A_ST)  v = {30'd0, m_flt, m_exp};
    endtask

    // Architectural effect of one clock edge: writes are visible from the next cycle on.
    task automatic m_apply(input bit we, input logic [31:0] a, input logic [31:0] d);
        bit clr0 = 0, clr1 = 0, bad = 0, tload = 0, set0 = 0;
        if (we) begin
            if (a[1:0] != 2'b00) bad = 1;
            else if (a < DEPTH * 4) begin
                m_mem[a >> 2]   = d;
                m_known[a >> 2] = 1;
            end
            else if (a == A_CYC) ;
            else if (a == A_TMR) tload = 1;
            else if (a == A_ST) begin
                clr0 = d[0];
                clr1 = d[1];
            end
            else bad = 1;
        end
        if (tload) begin
            m_tcount = d;
            m_trun   = (d != 0);
        end else if (m_trun) begin
            if (m_tcount == 1) begin
                set0   = 1;
                m_trun = 0;
            end
            m_tcount = m_tcount - 1;
        end
        m_exp = set0 || (m_exp && !clr0);
        m_flt = bad  || (m_flt && !clr1);
        m_cyc = m_cyc + 1;
    endtask

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic step(input bit we, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] got);
        logic [31:0] exp;
        bit known;
        we_dm = we;
        addr  = a;
        wd    = d;
        #1;
        got = rd_dm;
        m_read(a, exp, known);
        if (known) check($sformatf("rd@%h", a), rd_dm, exp);
        check("irq", 32'(timer_irq), 32'(m_exp));
        check("fault", 32'(fault), 32'(m_flt));
        m_apply(we, a, d);
        @(negedge clk);
    endtask

    logic [31:0] r, c0, c1, a, d;
    int op;

    initial begin
        for (int i = 0; i < DEPTH; i++) m_known[i] = 0;
        m_reset();

        repeat (2) @(negedge clk);
        addr = A_CYC; #1;
        check("rst_cyc", rd_dm, 32'h0);
        addr = A_TMR; #1;
        check("rst_tmr", rd_dm, 32'h0);
        check("rst_irq", 32'(timer_irq), 32'h0);
        check("rst_fault", 32'(fault), 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // buffered write, then committed write
        step(1, 32'h10, 32'hDEAD_BEEF, r);
        step(0, 32'h10, 0, r); check("wr_buf", r, 32'hDEAD_BEEF);
        step(0, 32'h10, 0, r); check("wr_ram", r, 32'hDEAD_BEEF);

        step(1, 32'h20, 32'h1, r);
        step(1, 32'h20, 32'h2, r);
        step(0, 32'h20, 0, r); check("b2b_same", r, 32'h2);
        step(1, 32'h20, 32'hA, r);
        step(1, 32'h24, 32'hB, r);
        step(0, 32'h20, 0, r); check("b2b_20", r, 32'hA);
        step(0, 32'h24, 0, r); check("b2b_24", r, 32'hB);

        // timer countdown and expiry
        step(1, A_TMR, 32'd5, r);
        for (int i = 0; i <= 5; i++) begin
            step(0, A_TMR, 0, r);
            check("tmr_cnt", r, 32'(5 - i));
        end
        check("tmr_irq_set", 32'(timer_irq), 32'h1);
        step(1, A_ST, 32'h1, r);
        step(0, A_TMR, 0, r);
        check("tmr_irq_clr", 32'(timer_irq), 32'h0);

        // expiry coinciding with a W1C of the expired bit
        step(1, A_TMR, 32'd3, r);
        step(0, A_TMR, 0, r);
        step(0, A_TMR, 0, r);
        step(1, A_ST, 32'h1, r);
        step(0, A_ST, 0, r);
        check("irq_set_wins", 32'(timer_irq), 32'h1);
        step(1, A_ST, 32'h1, r);

        // faults
        step(1, 32'h13, 32'h1111_1111, r);
        step(0, 32'h10, 0, r); check("misal_ram", r, 32'hDEAD_BEEF);
        check("misal_fault", 32'(fault), 32'h1);
        step(1, A_ST, 32'h2, r);
        step(1, 32'h400, 32'h2222_2222, r);
        step(0, 32'h400, 0, r); check("unmap_rd", r, 32'h0);
        check("unmap_fault", 32'(fault), 32'h1);
        step(1, A_ST, 32'h2, r);
        step(0, A_ST, 0, r); check("fault_clr", 32'(fault), 32'h0);
        step(1, 32'h400, 32'h0, r);
        step(1, A_ST + 32'h1, 32'h2, r);
        step(0, A_ST, 0, r); check("fault_set_wins", 32'(fault), 32'h1);
        step(1, A_ST, 32'h2, r);

        // cycle counter spacing and wrap
        step(0, A_CYC, 0, c0);
        repeat (7) step(0, 32'h0, 0, r);
        step(0, A_CYC, 0, c1);
        check("cyc_diff", c1 - c0, 32'd8);
        force dut.cycle_q = 32'hFFFF_FFFE;
        #1;
        release dut.cycle_q;
        m_cyc = 32'hFFFF_FFFE;
        step(0, A_CYC, 0, r); check("cyc_fe", r, 32'hFFFF_FFFE);
        step(0, A_CYC, 0, r); check("cyc_ff", r, 32'hFFFF_FFFF);
        step(0, A_CYC, 0, r); check("cyc_wrap", r, 32'h0);

        // reset while the timer runs and a write sits in the buffer
        step(1, 32'h30, 32'hAAAA_0000, r);
        step(0, 32'h30, 0, r);
        step(1, A_TMR, 32'd10, r);
        step(1, 32'h404, 32'h0, r);
        step(1, 32'h30, 32'h5555_5555, r);
        rst   = 1'b0;
        we_dm = 1'b0;
        addr  = A_TMR; #1;
        check("mrst_tmr", rd_dm, 32'h0);
        check("mrst_fault", 32'(fault), 32'h0);
        check("mrst_irq", 32'(timer_irq), 32'h0);
        addr = A_CYC; #1;
        check("mrst_cyc", rd_dm, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        m_reset();
        m_mem[32'h30 >> 2] = 32'hAAAA_0000;
        step(0, 32'h30, 0, r); check("mrst_lost", r, 32'hAAAA_0000);
        step(0, A_TMR, 0, r);  check("mrst_idle0", r, 32'h0);
        step(0, A_TMR, 0, r);  check("mrst_idle1", r, 32'h0);

        // randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            op = $urandom_range(0, 9);
            d  = $urandom;
            case (op)
                0, 1, 2, 3: step(1, 32'($urandom_range(0, 15)) << 2, d, r);
                4: begin
                    a = $urandom_range(0, DEPTH * 4 - 1);
                    step(0, a, d, r);
                end
                5: step(1, A_TMR, 32'($urandom_range(0, 8)), r);
                6: step(1, A_ST, 32'($urandom_range(0, 3)), r);
                7: step(0, BASE + (32'($urandom_range(0, 3)) << 2), d, r);
                8: begin
                    case ($urandom_range(0, 2))
                        0: a = 32'($urandom_range(0, DEPTH * 4 - 1)) | 32'h1;
                        1: a = BASE + 32'hC;
                        default: a = 32'hFFFF_0000;
                    endcase
                    step(1, a, d, r);
                end
                default: step(1, A_CYC, d, r);
            endcase
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
